// File: rtl/fifo_skew_ctrl_if.sv
// fifo_skew_ctrl_if: control bundle between the skew controller, loader stream and row FIFO bank
interface fifo_skew_ctrl_if #(
  parameter int NUM_ROW = 4,
  parameter int LW = 4
);
  logic start;
  logic [LW-1:0] len;
  logic stall;
  logic in_valid;
  logic in_ready;
  logic [NUM_ROW-1:0] fifo_full;
  logic [NUM_ROW-1:0] fifo_empty;
  logic [NUM_ROW-1:0] fifo_wren;
  logic [NUM_ROW-1:0] fifo_rden;
  logic [NUM_ROW-1:0] out_valid;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, len, stall, in_valid, fifo_full, fifo_empty,
    input in_ready, fifo_wren, fifo_rden, out_valid, busy, done, err
  );
  modport slave (
    input start, len, stall, in_valid, fifo_full, fifo_empty,
    output in_ready, fifo_wren, fifo_rden, out_valid, busy, done, err
  );
endinterface

// File: rtl/fifo_skew_ctrl.sv
// fifo_skew_ctrl: broadcast-fills a bank of row FIFOs, then drains them with a one-cycle-per-row diagonal skew
module fifo_skew_ctrl #(
  parameter int NUM_ROW = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LW = $clog2(FIFO_DEPTH) + 1
) (
  input logic clk,
  input logic rstn,
  fifo_skew_ctrl_if.slave io
);
  localparam int TW = $clog2(FIFO_DEPTH + NUM_ROW);
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;
  state_t state;
  logic [LW-1:0] len_q, wr_cnt;
  logic [TW-1:0] t;
  logic [NUM_ROW-1:0] sched;
  logic room, hs, last;
  for (genvar i = 0; i < NUM_ROW; i++) begin : g
    assign sched[i] = (int'(t) >= i) && (int'(t) < i + int'(len_q));
  end
  assign room = wr_cnt < len_q;
  assign io.in_ready = (state == FILL) && room && !(|io.fifo_full) && !io.err;
  assign hs = io.in_valid && io.in_ready;
  assign io.fifo_wren = {NUM_ROW{hs}};
  assign io.fifo_rden = (state == DRAIN && !io.stall) ? sched & ~io.fifo_empty : '0;
  assign io.out_valid = io.fifo_rden;
  // t stops at the last slot instead of wrapping
  assign last = t == TW'(len_q) + TW'(NUM_ROW - 2);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      len_q <= '0;
      wr_cnt <= '0;
      t <= '0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          len_q <= io.len > LW'(FIFO_DEPTH) ? LW'(FIFO_DEPTH) : io.len;
          wr_cnt <= '0;
          t <= '0;
          io.err <= 1'b0;
          state <= io.len == '0 ? DONE : FILL;
          io.busy <= io.len != '0;
          io.done <= io.len == '0;
        end
        FILL: begin
          if (room && |io.fifo_full) io.err <= 1'b1;
          if (hs) wr_cnt <= wr_cnt + LW'(1);
          if (hs && wr_cnt + LW'(1) == len_q) state <= DRAIN;
        end
        DRAIN: if (!io.stall) begin
          if (|(sched & io.fifo_empty)) io.err <= 1'b1;
          t <= last ? '0 : t + TW'(1);
          if (last) begin
            state <= DONE;
            io.busy <= 1'b0;
            io.done <= 1'b1;
          end
        end
        DONE: begin
          io.done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// tb_fifo_skew_ctrl: per-cycle scoreboard of the fill/skewed-drain schedule for NUM_ROW=4, FIFO_DEPTH=8
module tb_fifo_skew_ctrl;
  typedef struct packed {
    logic ir;
    logic [3:0] wren;
    logic [3:0] rden;
    logic [3:0] ov;
    logic busy;
    logic done;
    logic err;
  } obs_t;
  logic clk, rstn;
  obs_t exp_q[$];
  logic st_start[64], st_valid[64], st_stall[64];
  logic [3:0] st_len[64], st_empty[64], st_full[64];
  int ncmp, nerr;
  fifo_skew_ctrl_if #(.NUM_ROW(4), .LW(4)) io ();
  fifo_skew_ctrl #(.NUM_ROW(4), .FIFO_DEPTH(8)) dut (.clk(clk), .rstn(rstn), .io(io));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic obs_t sample();
    return {io.in_ready, io.fifo_wren, io.fifo_rden, io.out_valid, io.busy, io.done, io.err};
  endfunction
  // job started in cycle 0; expected outputs derived from the documented schedule
  task automatic plan(input int l, input logic [63:0] vp, input logic [63:0] sm, input int er, input logic e0, output int n);
    obs_t ex[64];
    int lq, cnt, c, t, es;
    lq = l > 8 ? 8 : l;
    cnt = 0;
    c = 1;
    t = 0;
    es = 0;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      ex[k] = '0;
      st_start[k] = k == 0;
      st_len[k] = 4'(l);
      st_valid[k] = vp[k];
      st_stall[k] = sm[k];
      st_empty[k] = er >= 0 ? 4'(1 << er) : 4'h0;
      st_full[k] = 4'h0;
    end
    while (cnt < lq) begin
      ex[c].ir = 1'b1;
      ex[c].busy = 1'b1;
      if (vp[c]) begin
        ex[c].wren = 4'hf;
        cnt++;
      end
      c++;
    end
    if (lq > 0)
      while (t <= lq + 2) begin
        ex[c].busy = 1'b1;
        if (!sm[c]) begin
          for (int i = 0; i < 4; i++)
            if (t >= i && t < i + lq) begin
              if (i == er) begin
                if (es == 0) es = c + 1;
              end else ex[c].rden[i] = 1'b1;
            end
          t++;
        end
        c++;
      end
    ex[c].done = 1'b1;
    n = c + 2;
    for (int k = 0; k < n; k++) begin
      ex[k].err = k == 0 ? e0 : (es > 0 && k >= es);
      ex[k].ov = ex[k].rden;
      exp_q.push_back(ex[k]);
    end
  endtask
  task automatic drive(input int k);
    @(posedge clk);
    #1;
    io.start = st_start[k];
    io.len = st_len[k];
    io.in_valid = st_valid[k];
    io.stall = st_stall[k];
    io.fifo_empty = st_empty[k];
    io.fifo_full = st_full[k];
  endtask
  task automatic test_reset();
    obs_t o;
    #12;
    o = sample();
    ncmp++;
    if (o !== '0) begin nerr++; $display("FAIL reset_state got %h want 0", o); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    o = sample();
    ncmp++;
    if (o !== '0) begin nerr++; $display("FAIL idle_after_reset got %h want 0", o); end
  endtask
  task automatic test_nominal();
    obs_t o, e;
    int n;
    plan(3, '1, 64'h0, -1, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL nominal c%0d got %h want %h", k, o, e); end
    end
  endtask
  task automatic test_stalls();
    obs_t o, e;
    int n;
    plan(3, '1, 64'h60, -1, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL stalls c%0d got %h want %h", k, o, e); end
    end
  endtask
  task automatic test_gaps_clamp();
    obs_t o, e;
    int n;
    plan(9, 64'haaaa_aaaa_aaaa_aaaa, 64'h0, -1, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL gaps_clamp c%0d got %h want %h", k, o, e); end
    end
  endtask
  task automatic test_zero_len();
    obs_t o, e;
    int n;
    plan(0, '1, 64'h0, -1, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL zero_len c%0d got %h want %h", k, o, e); end
    end
  endtask
  task automatic test_underflow();
    obs_t o, e;
    int n;
    plan(3, '1, 64'h0, 2, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL underflow c%0d got %h want %h", k, o, e); end
    end
    plan(3, '1, 64'h0, -1, 1'b1, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL err_clear c%0d got %h want %h", k, o, e); end
    end
  endtask
  task automatic test_ignored_start();
    obs_t o, e;
    int n;
    plan(3, '1, 64'h0, -1, 1'b0, n);
    st_start[2] = 1'b1;
    st_len[2] = 4'd1;
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL ignored_start c%0d got %h want %h", k, o, e); end
    end
  endtask
  task automatic test_overflow();
    obs_t o, e;
    int n;
    plan(4, '1, 64'h0, -1, 1'b0, n);
    st_full[2] = 4'b0100;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('{ir: 1'b1, wren: 4'hf, busy: 1'b1, default: '0});
    exp_q.push_back('{busy: 1'b1, default: '0});
    exp_q.push_back('{busy: 1'b1, err: 1'b1, default: '0});
    exp_q.push_back('{busy: 1'b1, err: 1'b1, default: '0});
    for (int k = 0; k < 5; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL overflow c%0d got %h want %h", k, o, e); end
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    o = sample();
    ncmp++;
    if (o !== '0) begin nerr++; $display("FAIL overflow_reset got %h want 0", o); end
  endtask
  task automatic test_mid_reset();
    obs_t o, e;
    int n;
    plan(3, '1, 64'h0, -1, 1'b0, n);
    for (int k = 0; k < 7; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL pre_reset c%0d got %h want %h", k, o, e); end
    end
    rstn = 1'b0;
    #1;
    o = sample();
    ncmp++;
    if (o !== '0) begin nerr++; $display("FAIL async_reset got %h want 0", o); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    plan(1, '1, 64'h0, -1, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      drive(k); @(negedge clk); o = sample(); e = exp_q.pop_front(); ncmp++;
      if (o !== e) begin nerr++; $display("FAIL post_reset c%0d got %h want %h", k, o, e); end
    end
  endtask
  initial begin
    ncmp = 0;
    nerr = 0;
    rstn = 1'b1;
    io.start = 1'b0;
    io.len = '0;
    io.stall = 1'b0;
    io.in_valid = 1'b0;
    io.fifo_full = '0;
    io.fifo_empty = '0;
    #1;
    rstn = 1'b0;
    test_reset();
    test_nominal();
    test_stalls();
    test_gaps_clamp();
    test_zero_len();
    test_underflow();
    test_ignored_start();
    test_overflow();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_skew_ctrl.md
# fifo_skew_ctrl

Sequencing controller for a bank of NUM_ROW row-input FIFOs feeding the systolic array. On each job it broadcast-fills every row FIFO with `len` input vectors, then drains them with a diagonal skew: row i starts i cycles after row 0. This produces the staggered wavefront the array expects. It sits between the operand loader stream and the per-row FIFO bank; the FIFO data buses bypass it and only control passes through it.

## Interface
Parameters:
- NUM_ROW, 4, number of row FIFOs / array rows (≥2)
- FIFO_DEPTH, 8, entries per row FIFO (power of 2)
- LW, $clog2(FIFO_DEPTH)+1, width of `len`

Ports:
- clk  in  1  clock
- rstn  in  1  reset; rstn, asynchronous, active-low; clock clk
- start  in  1  job start pulse, sampled only in IDLE
- len  in  LW  vectors per row for this job, sampled with start
- stall  in  1  array backpressure; freezes the drain schedule
- in_valid  in  1  input vector valid
- in_ready  out  1  controller accepts input vector
- fifo_full  in  NUM_ROW  per-row FIFO full flags
- fifo_empty  in  NUM_ROW  per-row FIFO empty flags
- fifo_wren  out  NUM_ROW  per-row FIFO write enables
- fifo_rden  out  NUM_ROW  per-row FIFO read enables
- out_valid  out  NUM_ROW  row data valid to the array (equals fifo_rden)
- busy  out  1  job in progress (registered)
- done  out  1  one-cycle job-complete pulse (registered)
- err  out  1  sticky underflow/overflow flag (registered)

## Operation
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - start=1 latches len_q and goes to FILL.
  - If len > FIFO_DEPTH, len_q is clamped to FIFO_DEPTH.
  - If len == 0, the FSM goes directly to DONE and makes no FIFO access.
  - start clears err.
- FILL:
  - in_ready = (wr_cnt < len_q) & ~|fifo_full.
  - On each handshake (in_valid & in_ready), fifo_wren = all ones and wr_cnt increments.
  - When the handshake makes wr_cnt == len_q, the FSM goes to DRAIN next cycle.
  - If any fifo_full is seen while wr_cnt < len_q, err is set and in_ready is held low. The FSM stays in FILL (the job hangs until reset; this is by design).
- DRAIN: t counter starts at 0 and runs to len_q+NUM_ROW-2.
  - sched[i] = (t ≥ i) & (t < i+len_q).
  - fifo_rden[i] = sched[i] & ~stall & ~fifo_empty[i].
  - sched[i] & ~stall & fifo_empty[i] sets err; that row's read is suppressed for that slot and the schedule still advances.
  - stall=1: all rden are 0 and t holds.
  - After the stall-free cycle at t = len_q+NUM_ROW-2, the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Signal sources:
  - in_ready, fifo_wren, fifo_rden and out_valid are combinational from state, counters and inputs. They are 0 outside FILL/DRAIN.
  - busy=1 in FILL and DRAIN.
- Counters: wr_cnt is LW bits. t is $clog2(FIFO_DEPTH+NUM_ROW) bits and must not wrap at its maximum value.
- start while not IDLE is ignored.

## Timing
- Reset values: state=IDLE, wr_cnt=0, t=0, busy=0, done=0, err=0. All enables, in_ready and out_valid are 0.
- Reset mid-job aborts immediately to IDLE. The FIFO bank shares rstn, so no residual data survives.
- Latency, start to first in_ready: 1 cycle.
- Drain length: len_q+NUM_ROW-1 stall-free cycles. Each stall cycle adds exactly one cycle.
- Row FIFO rdata is combinational, so data is valid in the same cycle as out_valid[i]. The pointer advances at that edge.
- Example, NUM_ROW=4, len=3, start at cycle 0, in_valid constantly 1:
  - Writes occur in cycles 1–3.
  - DRAIN starts at cycle 4.
  - Row 0 reads in cycles 4–6; row 3 reads in cycles 7–9.
  - done=1 at cycle 10; IDLE at cycle 11.

## Test plan
- Nominal job:
  - Stimulus: NUM_ROW=4, len=3, in_valid constantly 1.
  - Required: wren in cycles 1–3; rden[i] in cycles 4+i..6+i; done at cycle 10 only; busy high in cycles 1–9; err=0.
- Stalls:
  - Stimulus: same job, with stall=1 at cycles 5 and 6.
  - Required: no rden in cycles 5–6; the schedule shifts by 2; done at cycle 12; every row gets exactly 3 reads.
- Input gaps, len clamp, zero length:
  - Stimulus: in_valid toggling 1,0,1,0…, with len=9 and FIFO_DEPTH=8.
  - Required: 8 writes only, on the valid cycles; then DRAIN with an 11-cycle schedule.
  - Stimulus: len=0.
  - Required: done one cycle after start, with no wren or rden.
- Underflow:
  - Stimulus: force fifo_empty[2]=1 during DRAIN.
  - Required: rden[2] stays 0; err rises at row 2's first slot and stays high; the other rows read normally; done still occurs on schedule; the next start clears err.
- Reset and ignored start:
  - Stimulus: rstn low at DRAIN t=2.
  - Required: all outputs are 0 asynchronously; the FSM is IDLE after release.
  - Stimulus: start pulsed during FILL.
  - Required: the start is ignored.
